hw9_smultiplier: RTL and testbench

Sequential unsigned shift-add multiplier that computes `product = word1 * word2` over several clock cycles using a Start/Ready handshake. It is the multiplicative counterpart of the lab's shift-subtract divider: one controller FSM, a datapath (multiplicand register, accumulator/multiplier register, carry bit), and an iteration counter. The block is used standalone in the lab and as the multiply unit that feeds the divider in round-trip checks (`product / word2` must return `word1`, remainder 0).

---
 rtl/hw9_smultiplier.sv | 101 ++++++++++
 tb/tb_hw9_smultiplier.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hw9_smultiplier.sv
// Sequential unsigned shift-add multiplier with a Start/Ready handshake.
// One multiplier bit is handled per TEST/(ADD)/SHIFT pass, LSB first. The
// accumulator lives in the upper half of P and the multiplier in the lower
// half. Each SHIFT moves the carry into the top bit and drops the bit that
// has just been consumed.
module hw9_smultiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   word1,
  input  logic [WIDTH-1:0]   word2,
  output logic [2*WIDTH-1:0] product,
  output logic               Ready,
  output logic [3:0]         state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    TEST  = 4'd1,
    ADD   = 4'd2,
    SHIFT = 4'd3,
    DONE  = 4'd4
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;

  // The sum is one bit wider than the operands so that the carry-out is kept.
  assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Controller next state and datapath updates. Every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = word1;
          p_d     = {{WIDTH{1'b0}}, word2};
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = TEST;
        end
      end
      TEST:  state_d = p_q[0] ? ADD : SHIFT;
      ADD: begin
        {c_d, p_d[2*WIDTH-1:WIDTH]} = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        p_d     = {c_q, p_q[2*WIDTH-1:1]};
        c_d     = 1'b0;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : TEST;
      end
      DONE: begin
        prod_d  = p_q;
        state_d = IDLE;
      end
      // Unused codes recover to IDLE on the next edge.
      default: state_d = IDLE;
    endcase
  end

  assign product = prod_q;
  assign Ready   = (state_q == IDLE);
  assign state   = state_q;

endmodule

// File: tb/tb_hw9_smultiplier.sv
// Directed bench for hw9_smultiplier (WIDTH = 4). It runs a vector table,
// multi-cycle corner sequences and an exhaustive operand sweep.
module tb_hw9_smultiplier;

  logic       clk = 1'b0;
  logic       reset, Start;
  logic [3:0] word1, word2;
  logic [7:0] product;
  logic       Ready;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  int seq [0:40];
  int lat;
  bit saw_add, hold_ok;

  typedef struct {
    logic [3:0] w1;
    logic [3:0] w2;
    logic [7:0] prod;
    int         lat;
  } vec_t;

  vec_t tbl [5];
  int   exp_seq [13];

  always #5 clk = ~clk;

  hw9_smultiplier #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .word1(word1), .word2(word2),
    .product(product), .Ready(Ready), .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start an operation at the next negedge and drop Start right after E0.
  // The task records the state after each edge and the number of edges until
  // Ready rises. It also checks that product holds prev while the block is busy.
  task automatic run_op(input logic [3:0] w1, input logic [3:0] w2, input logic [7:0] prev);
    @(negedge clk); word1 = w1; word2 = w2; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    lat = 0; saw_add = 0; hold_ok = 1; seq[0] = int'(state);
    while (!Ready && lat < 40) begin
      if (product !== prev) hold_ok = 0;
      if (state == 4'd2) saw_add = 1;
      @(posedge clk); #1;
      lat++;
      seq[lat] = int'(state);
    end
  endtask

  initial begin
    logic [7:0] prev;
    int         hi;

    tbl[0] = '{4'd13, 4'd11, 8'd143, 12};
    tbl[1] = '{4'd15, 4'd15, 8'd225, 13};
    tbl[2] = '{4'd7,  4'd0,  8'd0,   9};
    tbl[3] = '{4'd2,  4'd9,  8'd18,  11};
    tbl[4] = '{4'd10, 4'd8,  8'd80,  10};
    exp_seq = '{1, 2, 3, 1, 2, 3, 1, 3, 1, 2, 3, 4, 0};

    // Reset state
    reset = 1'b1; Start = 1'b0; word1 = '0; word2 = '0;
    #1;
    chk("rst_product", product, 0);
    chk("rst_ready", Ready, 1);
    chk("rst_state", state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Vector table
    prev = 8'd0;
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].w1, tbl[i].w2, prev);
      chk($sformatf("tbl%0d_product", i), product, tbl[i].prod);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_hold", i), hold_ok, 1);
      chk($sformatf("tbl%0d_test_first", i), seq[0], 1);
      chk($sformatf("tbl%0d_add_seen", i), saw_add, (tbl[i].w2 != 0));
      if (i == 0)
        for (int k = 0; k < 13; k++) chk($sformatf("seq13x11_%0d", k), seq[k], exp_seq[k]);
      prev = tbl[i].prod;
    end

    // Toggle Start and change the operands while busy: neither has any effect
    @(negedge clk); word1 = 4'd9; word2 = 4'd6; Start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!Ready && lat < 40) begin
      if (lat < 6) begin Start = (lat % 2 == 0); word1 = 4'd1; word2 = 4'd1; end
      else Start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("toggle_product", product, 54);
    chk("toggle_latency", lat, 11);
    repeat (3) @(posedge clk);
    #1;
    chk("toggle_no_extra_ready", Ready, 1);
    chk("toggle_no_extra_state", state, 0);
    chk("toggle_no_extra_product", product, 54);

    // Back-to-back: 0*15, then 3*5 with Start held high throughout
    @(negedge clk); word1 = 4'd0; word2 = 4'd15; Start = 1'b1;
    @(posedge clk); #1; word1 = 4'd3; word2 = 4'd5;
    lat = 0;
    while (!Ready && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_first_product", product, 0);
    chk("b2b_first_latency", lat, 13);
    hi = 0;
    while (Ready && hi < 40) begin @(posedge clk); #1; hi++; end
    chk("b2b_ready_cycles", hi, 1);
    chk("b2b_second_state", state, 1);
    lat = 0;
    while (!Ready && lat < 40) begin @(posedge clk); #1; lat++; end
    Start = 1'b0;
    chk("b2b_second_product", product, 15);
    chk("b2b_second_latency", lat, 11);

    // Asynchronous reset mid-operation, then accept on the first edge after release
    @(negedge clk); word1 = 4'd9; word2 = 4'd6; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_product", product, 0);
    chk("async_rst_ready", Ready, 1);
    chk("async_rst_state", state, 0);
    @(negedge clk); reset = 1'b0; word1 = 4'd4; word2 = 4'd3; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    chk("post_rst_accept", state, 1);
    lat = 0;
    while (!Ready && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("post_rst_product", product, 12);
    chk("post_rst_latency", lat, 11);

    // Exhaustive sweep over all operand pairs
    prev = 8'd12;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), prev);
        chk($sformatf("sweep_%0dx%0d_product", a, b), product, a * b);
        chk($sformatf("sweep_%0dx%0d_latency", a, b), lat, 9 + $countones(4'(b)));
        prev = 8'(a * b);
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
